// File: rtl/led_pattern_seq_pkg.sv
// Shared mode codes, seed patterns and small types for the LED pattern sequencer.
package led_pattern_seq_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC   = 2'b00,
      MODE_RUN      = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_COUNT    = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [7:0] STATIC_PAT    = 8'hAA;
   localparam logic [7:0] SEED_RUN      = 8'h01;
   localparam logic [7:0] SEED_PINGPONG = 8'h01;
   localparam logic [7:0] SEED_COUNT    = 8'h00;

   function automatic logic [7:0] mode_seed(input logic [1:0] m);
      logic [7:0] seed;
      case (m)
         MODE_STATIC:   seed = STATIC_PAT;
         MODE_RUN:      seed = SEED_RUN;
         MODE_PINGPONG: seed = SEED_PINGPONG;
         default:       seed = SEED_COUNT;
      endcase
      return seed;
   endfunction

endpackage

// File: rtl/led_pattern_seq_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse on each debounced press (falling edge of the debounced level).
module key_debounce #(
   parameter int DB_CNT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic key_press
);

   localparam int DB_W = (DB_CNT > 2) ? $clog2(DB_CNT) : 1;

   logic            key_s1_q;
   logic            key_s_q;
   logic            level_q;
   logic            press_q;
   logic [DB_W-1:0] cnt_q;
   logic            settle;

   // Level flips on the DB_CNT-th consecutive cycle that the synced key disagrees.
   assign settle = (key_s_q != level_q) && (cnt_q == DB_W'(DB_CNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q <= 1'b1;
         key_s_q  <= 1'b1;
         level_q  <= 1'b1;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         key_s1_q <= key_n;
         key_s_q  <= key_s1_q;
         press_q  <= settle & level_q;
         if (key_s_q == level_q) begin
            cnt_q <= '0;
         end else if (settle) begin
            level_q <= key_s_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign key_level = level_q;
   assign key_press = press_q;

endmodule

// File: rtl/led_pattern_seq.sv
// Eight-LED pattern sequencer: mode-selected pattern stepped by a prescaler,
// with a debounced push-button toggling pause. LEDs are driven active-low.
module led_pattern_seq
   import led_pattern_seq_pkg::*;
#(
   parameter int STEP_DIV = 12_500_000,
   parameter int DB_CNT   = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       key_n,
   output logic [7:0] led
);

   localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

   logic [1:0]       mode_s1_q;
   logic [1:0]       mode_s_q;
   mode_e            mode_q;
   logic             load_pending_q;
   logic [7:0]       pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic             paused_q;
   logic             key_level;
   logic             key_press;
   logic             press_ok;
   logic             load;
   logic             tick;
   logic [7:0]       shl, shr;

   key_debounce #(.DB_CNT(DB_CNT)) u_key (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n     (key_n),
      .key_level (key_level),
      .key_press (key_press)
   );

   // A press pulse is only honoured while the debounced level is still low.
   assign press_ok = key_press & ~key_level;
   assign load     = load_pending_q | (mode_s_q != mode_q);
   assign tick     = ~paused_q & (cnt_q == CNT_W'(STEP_DIV - 1));
   assign shl      = pat_q << 1;
   assign shr      = pat_q >> 1;

   always_comb begin
      pat_d = pat_q;
      dir_d = dir_q;
      cnt_d = cnt_q;
      if (load) begin
         // Seed wins over a coincident tick; that step is dropped.
         pat_d = mode_seed(mode_s_q);
         dir_d = DIR_LEFT;
         cnt_d = '0;
      end else if (!paused_q) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            case (mode_q)
               MODE_RUN: pat_d = {pat_q[6:0], pat_q[7]};
               MODE_PINGPONG: begin
                  if (dir_q == DIR_LEFT) begin
                     pat_d = shl;
                     if (shl == 8'h80) dir_d = DIR_RIGHT;
                  end else begin
                     pat_d = shr;
                     if (shr == 8'h01) dir_d = DIR_LEFT;
                  end
               end
               MODE_COUNT: pat_d = pat_q + 8'd1;
               default: pat_d = pat_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1_q      <= 2'b00;
         mode_s_q       <= 2'b00;
         mode_q         <= MODE_STATIC;
         load_pending_q <= 1'b1;
         pat_q          <= 8'h00;
         cnt_q          <= '0;
         dir_q          <= DIR_LEFT;
         paused_q       <= 1'b0;
      end else begin
         mode_s1_q <= mode;
         mode_s_q  <= mode_s1_q;
         if (load) begin
            mode_q         <= mode_e'(mode_s_q);
            load_pending_q <= 1'b0;
         end
         pat_q <= pat_d;
         cnt_q <= cnt_d;
         dir_q <= dir_d;
         if (press_ok) paused_q <= ~paused_q;
      end
   end

   assign led = ~pat_q;

endmodule
